branch_predictor_table: RTL
===========================

# branch_predictor_table

Parametrised, PC-indexed branch direction predictor for the 5-stage pipeline, replacing the single global 2-bit predictor. It holds a table of saturating counters that the ID stage reads combinationally to decide the early branch redirect. The EX stage writes each resolved outcome back to the counter selected at lookup. Built-in branch and mispredict counters expose prediction accuracy to the testbench.

## Interface
- IDX_BITS, 4: table index width; table holds 2^IDX_BITS counters.
- CNT_BITS, 2: counter width, legal range 1..4.
- INIT_CNT, 2^(CNT_BITS-1): reset value of every counter (weakly taken).
- HIST_BITS, 4: global history width, legal range 1..IDX_BITS; used only with GSHARE_EN.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- lookup_valid_i  in  1  ID stage holds a branch whose prediction is needed.
- lookup_pc_i  in  32  PC of the instruction in ID.
- predict_o  out  1  predicted taken; forced 0 when lookup_valid_i=0.
- predict_idx_o  out  IDX_BITS  index used for this lookup; carried through ID_EX to EX.
- update_valid_i  in  1  EX stage resolves a branch this cycle.
- update_idx_i  in  IDX_BITS  index carried from lookup.
- update_taken_i  in  1  actual outcome (ALU zero).
- update_mispredict_i  in  1  actual outcome differs from the carried prediction.
- branch_cnt_o  out  32  resolved branches since reset.
- mispredict_cnt_o  out  32  mispredicted branches since reset.

## Operation
- Storage: cnt[0 .. 2^IDX_BITS-1], each CNT_BITS wide.
- Index: idx = lookup_pc_i[IDX_BITS+1:2]. Bits [1:0] are ignored.
- Prediction: predict_o = lookup_valid_i & cnt[idx][CNT_BITS-1] (counter MSB). predict_idx_o = idx, independent of lookup_valid_i.
- Update when update_valid_i=1:
  - taken=1: cnt[update_idx_i] = min(cnt+1, 2^CNT_BITS-1).
  - taken=0: cnt[update_idx_i] = max(cnt-1, 0).
  - All other entries hold their values.
- Statistics:
  - branch_cnt_o increments on every update_valid_i.
  - mispredict_cnt_o increments when update_valid_i & update_mispredict_i.
  - Both saturate at 32'hFFFF_FFFF and do not wrap.
- Reset: every counter = INIT_CNT; statistics = 0; history = 0. predict_o therefore reads lookup_valid_i & INIT_CNT[CNT_BITS-1], which is 1 for the default INIT_CNT. predict_idx_o is purely combinational from lookup_pc_i.
- No FSM beyond the per-entry saturating counters. The block never stalls and never applies back-pressure.

## Timing
- Lookup has zero latency: predict_o and predict_idx_o are combinational from lookup_pc_i and the current state.
- An update takes effect at the rising edge on which update_valid_i=1. It becomes visible to a lookup in the following cycle.
- Simultaneous lookup and update of the same index: the lookup sees the pre-update value. There is no bypass.
- Only one update per cycle is possible, so there are no write conflicts.
- Reset asserted mid-operation: rst_i has priority. Any update in that same cycle is discarded and the statistics do not increment.
- update_* inputs are ignored when update_valid_i=0. This covers X-safe bubbles and flushed branches, which the pipeline delivers with update_valid_i deasserted.

## Configuration
- GSHARE_EN defined:
  - A HIST_BITS global history register ghr is added.
  - Index becomes idx = lookup_pc_i[IDX_BITS+1:2] ^ {{(IDX_BITS-HIST_BITS){1'b0}}, ghr}.
  - On each valid update, ghr <= {ghr[HIST_BITS-2:0], update_taken_i}. For HIST_BITS=1, ghr <= update_taken_i.
  - History is non-speculative and is cleared by reset. A lookup in the same cycle as an update uses the old ghr.
- GSHARE_EN undefined: no history register; idx is the plain PC bits described under Operation. HIST_BITS is unused.

## Test plan
- Reset with defaults, lookup_valid_i=1, lookup_pc_i=0x40 -> predict_o=1, predict_idx_o=0, both statistics 0.
- Saturation: three not-taken updates to idx 3, then lookup PC 0x0C -> predict_o=0 and cnt[3]=0. A fourth not-taken update keeps cnt[3]=0. Two taken updates -> predict_o=1.
- Aliasing and isolation: PCs 0x08 and 0x48 map to idx 2 and share a counter. A not-taken update to idx 2 leaves a lookup at PC 0x0C (idx 3) at predict_o=1.
- Same-cycle collision: update not-taken idx 5 starting from cnt=2, while lookup PC 0x14 in the same cycle -> predict_o=1 that cycle and 0 the next.
- Statistics and reset priority:
  - 10 updates, 3 of them with update_mispredict_i=1 -> branch_cnt_o=10, mispredict_cnt_o=3.
  - rst_i asserted together with an update -> both statistics 0 and cnt at INIT_CNT.
- GSHARE_EN, HIST_BITS=4: updates taken, taken, not-taken -> ghr=4'b0110. Lookup PC 0x00 -> predict_idx_o=6.

Source files
------------

// File: rtl/branch_predictor_table.sv
// PC-indexed table of saturating direction counters with branch/mispredict statistics.
// Optional global-history (gshare) indexing is enabled by defining GSHARE_EN.
module branch_predictor_table #(
  parameter int IDX_BITS  = 4,
  parameter int CNT_BITS  = 2,
  parameter int INIT_CNT  = 2 ** (CNT_BITS - 1),
  parameter int HIST_BITS = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                lookup_valid_i,
  input  logic [31:0]         lookup_pc_i,
  output logic                predict_o,
  output logic [IDX_BITS-1:0] predict_idx_o,
  input  logic                update_valid_i,
  input  logic [IDX_BITS-1:0] update_idx_i,
  input  logic                update_taken_i,
  input  logic                update_mispredict_i,
  output logic [31:0]         branch_cnt_o,
  output logic [31:0]         mispredict_cnt_o
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0] INIT_VAL = CNT_BITS'(INIT_CNT);

  logic [IDX_BITS-1:0]               lookup_idx;
  logic [ENTRIES-1:0][CNT_BITS-1:0]  cnt_vec;
  logic [31:0]                       branch_cnt_reg;
  logic [31:0]                       mispredict_cnt_reg;
  logic                              unused_pc_bits;

  // Byte-offset and upper PC bits never contribute to the index.
  assign unused_pc_bits = ^{lookup_pc_i[31:IDX_BITS+2], lookup_pc_i[1:0]};

`ifdef GSHARE_EN
  logic [HIST_BITS-1:0] ghr_reg;
  logic [HIST_BITS-1:0] ghr_next;

  // Truncating the concatenation drops the oldest bit, which also covers HIST_BITS=1.
  assign ghr_next = HIST_BITS'({ghr_reg, update_taken_i});

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ghr_reg <= '0;
    end else if (update_valid_i) begin
      ghr_reg <= ghr_next;
    end
  end

  assign lookup_idx = lookup_pc_i[IDX_BITS+1:2] ^ IDX_BITS'(ghr_reg);
`else
  localparam int unused_hist_bits = HIST_BITS;
  assign lookup_idx = lookup_pc_i[IDX_BITS+1:2];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic [CNT_BITS-1:0] cnt_reg;
      logic [CNT_BITS-1:0] cnt_next;

      always_comb begin
        cnt_next = cnt_reg;
        if (update_valid_i && (update_idx_i == IDX_BITS'(gi))) begin
          if (update_taken_i) begin
            if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + CNT_BITS'(1);
          end else begin
            if (cnt_reg != '0) cnt_next = cnt_reg - CNT_BITS'(1);
          end
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cnt_reg <= INIT_VAL;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign cnt_vec[gi] = cnt_reg;
    end
  endgenerate

  // Lookup reads the registered state, so a same-cycle update is not bypassed.
  assign predict_idx_o = lookup_idx;
  assign predict_o     = lookup_valid_i & cnt_vec[lookup_idx][CNT_BITS-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_cnt_reg     <= '0;
      mispredict_cnt_reg <= '0;
    end else if (update_valid_i) begin
      if (branch_cnt_reg != '1) branch_cnt_reg <= branch_cnt_reg + 32'd1;
      if (update_mispredict_i && (mispredict_cnt_reg != '1)) begin
        mispredict_cnt_reg <= mispredict_cnt_reg + 32'd1;
      end
    end
  end

  assign branch_cnt_o     = branch_cnt_reg;
  assign mispredict_cnt_o = mispredict_cnt_reg;

endmodule
